dmem_sonar_responder: RTL and testbench

//  Responder end of the processor's data-memory port (address_dmem/data/wren -> q_dmem). Decodes each

---
 rtl/dmem_sonar_responder_if.sv | 22 ++
 rtl/dmem_sonar_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_dmem_sonar_responder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_sonar_responder_if.sv
// Data-memory port bundle: processor-side access signals plus the data-RAM side they fan out to.
// The responder takes the slave view; the processor/RAM environment takes the master view.
interface dmem_sonar_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  modport slave (
    input  address_dmem, data, wren, ram_q,
    output q_dmem, ram_address, ram_data, ram_wren
  );

  modport master (
    output address_dmem, data, wren, ram_q,
    input  q_dmem, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/dmem_sonar_responder.sv
// Data-memory responder: passes RAM-region accesses through to the data RAM and maps a
// 16-word MMIO window onto an ultrasonic ranging unit (trigger pulse + echo-width timer).
module dmem_sonar_responder #(
  parameter logic [31:0] MMIO_BASE     = 32'h0000_0FF0,
  parameter int unsigned TRIG_CYCLES   = 500,
  parameter int unsigned TICK_DIV      = 50,
  parameter int unsigned TIMEOUT_TICKS = 38000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  dmem_sonar_responder_if.slave  bus,
  output logic                   sonar_trig,
  input  logic                   sonar_echo,
  output logic                   irq
);

  localparam int unsigned PS_W = $clog2(TICK_DIV + 1);
  localparam int unsigned TR_W = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [TR_W-1:0]  TR_LAST = TR_W'(TRIG_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_DONE
  } state_e;

  typedef enum logic [3:0] {
    REG_CMD    = 4'd0,
    REG_STATUS = 4'd1,
    REG_RESULT = 4'd2,
    REG_COUNT  = 4'd3
  } reg_e;

  state_e            state_q;
  logic              trig_q;
  logic [TR_W-1:0]   trig_cnt_q;
  logic [PS_W-1:0]   presc_q;
  logic [TO_W-1:0]   tmo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              to_pend_q;
  logic [CNT_W-1:0]  result_q;
  logic              done_q;
  logic              timeout_q;
  logic [31:0]       count_q;

  logic              echo_s1_q;
  logic              echo_s2_q;
  logic              echo_d_q;
  logic              hit_q;
  logic [31:0]       mmio_q;

  // Address decode. A non-wrapping subtraction with zero upper bits is the window test.
  logic [31:0] offset_full;
  logic [3:0]  offset;
  logic        mmio_hit;

  assign offset_full = bus.address_dmem - MMIO_BASE;
  assign offset      = offset_full[3:0];
  assign mmio_hit    = (bus.address_dmem >= MMIO_BASE) && (offset_full[31:4] == 28'd0);

  logic mmio_wr;
  logic start_req;
  logic clr_req;
  logic count_clr;
  logic rd_result;

  assign mmio_wr   = mmio_hit && bus.wren;
  assign start_req = mmio_wr && (offset == REG_CMD) && bus.data[0];
  assign clr_req   = mmio_wr && (offset == REG_CMD) && bus.data[1];
  assign count_clr = mmio_wr && (offset == REG_COUNT);
  assign rd_result = mmio_hit && !bus.wren && (offset == REG_RESULT);

  // RAM side is a straight passthrough; MMIO stores are kept away from the RAM.
  assign bus.ram_address = bus.address_dmem;
  assign bus.ram_data    = bus.data;
  assign bus.ram_wren    = bus.wren && !mmio_hit;
  assign bus.q_dmem      = hit_q ? mmio_q : bus.ram_q;

  assign sonar_trig = trig_q;
  assign irq        = done_q;

  logic busy;
  logic tick;
  logic echo_rise;
  logic echo_fall;

  assign busy      = (state_q != ST_IDLE);
  assign tick      = (presc_q == PS_LAST);
  assign echo_rise = echo_s2_q && !echo_d_q;
  assign echo_fall = !echo_s2_q && echo_d_q;

  logic [31:0] rd_data;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    rd_data = 32'd0;
    unique case (offset)
      REG_STATUS: rd_data = {29'd0, timeout_q, done_q, busy};
      REG_RESULT: rd_data = 32'(result_q);
      REG_COUNT:  rd_data = count_q;
      default:    rd_data = 32'd0;
    endcase
  end

  // Echo is asynchronous: two flops to resynchronise, a third to detect edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_d_q  <= 1'b0;
    end else begin
      echo_s1_q <= sonar_echo;
      echo_s2_q <= echo_s1_q;
      echo_d_q  <= echo_s2_q;
    end
  end

  // hit_q resets to 1 so the load mux selects the zeroed MMIO register, holding q_dmem at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_q  <= 1'b1;
      mmio_q <= 32'd0;
    end else begin
      hit_q  <= mmio_hit;
      mmio_q <= mmio_hit ? rd_data : 32'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      trig_q     <= 1'b0;
      trig_cnt_q <= '0;
      presc_q    <= '0;
      tmo_q      <= '0;
      cnt_q      <= '0;
      to_pend_q  <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments; a later assignment in this block overrides an earlier
      // one, which is how a same-edge completion beats a clear and a COUNT store beats the increment.
      if (clr_req) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (rd_result) begin
        done_q <= 1'b0;
      end

      if (state_q inside {ST_WAIT_ECHO, ST_MEASURE}) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
      end else begin
        presc_q <= '0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            state_q    <= ST_TRIG;
            trig_q     <= 1'b1;
            trig_cnt_q <= '0;
            timeout_q  <= 1'b0;
          end
        end

        ST_TRIG: begin
          if (trig_cnt_q == TR_LAST) begin
            state_q   <= ST_WAIT_ECHO;
            trig_q    <= 1'b0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            to_pend_q <= 1'b0;
          end else begin
            trig_cnt_q <= trig_cnt_q + 1'b1;
          end
        end

        // Only a low->high seen here starts a measurement; an echo already high is stale.
        ST_WAIT_ECHO: begin
          if (echo_rise) begin
            state_q <= ST_MEASURE;
            tmo_q   <= '0;
            cnt_q   <= '0;
          end else if (tick) begin
            if (tmo_q == TO_LAST) begin
              state_q   <= ST_DONE;
              to_pend_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end

        ST_MEASURE: begin
          if (echo_fall) begin
            state_q <= ST_DONE;
          end else if (tick) begin
            if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (tmo_q == TO_LAST) begin
              state_q   <= ST_DONE;
              to_pend_q <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_q   <= ST_IDLE;
          result_q  <= cnt_q;
          done_q    <= 1'b1;
          timeout_q <= to_pend_q;
          count_q   <= count_q + 32'd1;
        end

        default: begin
          state_q <= ST_IDLE;
          trig_q  <= 1'b0;
        end
      endcase

      if (count_clr) begin
        count_q <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_sonar_responder.sv
// Directed bench for dmem_sonar_responder: a table of bus accesses for decode/passthrough,
// then hand-written sequences for full measurement, timeout, stale echo, busy start and reset.
module tb_dmem_sonar_responder;

  localparam logic [31:0] MMIO_BASE  = 32'h0000_0FF0;
  localparam logic [31:0] A_CMD      = MMIO_BASE + 32'd0;
  localparam logic [31:0] A_STATUS   = MMIO_BASE + 32'd1;
  localparam logic [31:0] A_RESULT   = MMIO_BASE + 32'd2;
  localparam logic [31:0] A_COUNT    = MMIO_BASE + 32'd3;
  localparam logic [31:0] IDLE_ADDR  = 32'h0000_0100;

  logic clock;
  logic reset;
  logic sonar_trig;
  logic sonar_echo;
  logic irq;

  dmem_sonar_responder_if bus_if ();

  dmem_sonar_responder #(
    .MMIO_BASE     (MMIO_BASE),
    .TRIG_CYCLES   (4),
    .TICK_DIV      (2),
    .TIMEOUT_TICKS (64),
    .CNT_W         (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_if),
    .sonar_trig (sonar_trig),
    .sonar_echo (sonar_echo),
    .irq        (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous data RAM model, 1-cycle read latency, 256 words.
  logic [31:0] ram_mem [256];
  always @(posedge clock) begin
    if (bus_if.ram_wren) ram_mem[bus_if.ram_address[7:0]] <= bus_if.ram_data;
    bus_if.ram_q <= ram_mem[bus_if.ram_address[7:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    bus_if.address_dmem = a;
    bus_if.data         = d;
    bus_if.wren         = 1'b1;
    @(negedge clock);
    bus_if.wren         = 1'b0;
    bus_if.address_dmem = IDLE_ADDR;
    bus_if.data         = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] q);
    @(negedge clock);
    bus_if.address_dmem = a;
    bus_if.wren         = 1'b0;
    @(negedge clock);
    q = bus_if.q_dmem;
    bus_if.address_dmem = IDLE_ADDR;
  endtask

  task automatic wait_irq(input int max_cyc, output int cyc);
    cyc = 0;
    while (!irq && cyc < max_cyc) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic count_trig(output int n);
    n = 0;
    while (sonar_trig && n < 50) begin
      n++;
      @(negedge clock);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_wren;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t wv(input logic [31:0] a, input logic [31:0] d, input logic w);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.wdata = d; v.exp_wren = w; v.exp_q = 32'd0;
    return v;
  endfunction

  function automatic vec_t rv(input logic [31:0] a, input logic [31:0] q);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.wdata = 32'd0; v.exp_wren = 1'b0; v.exp_q = q;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          n;
    int          cyc;

    // RAM words aliasing the MMIO window's low address bits hold non-zero
    // markers so a wrong load mux or a leaked MMIO store shows up.
    vecs.push_back(wv(32'h0000_0010, 32'hDEAD_BEEF, 1'b1));
    vecs.push_back(rv(32'h0000_0010, 32'hDEAD_BEEF));
    vecs.push_back(wv(32'h0000_00F0, 32'hBAD0_0000, 1'b1));
    vecs.push_back(wv(32'h0000_00F1, 32'hBAD0_0001, 1'b1));
    vecs.push_back(wv(32'h0000_00F2, 32'hBAD0_0002, 1'b1));
    vecs.push_back(wv(32'h0000_00F3, 32'hBAD0_0003, 1'b1));
    vecs.push_back(wv(A_STATUS,      32'hFFFF_FFFF, 1'b0));
    vecs.push_back(rv(A_STATUS,      32'd0));
    vecs.push_back(rv(32'h0000_00F1, 32'hBAD0_0001));
    vecs.push_back(rv(A_CMD,         32'd0));
    vecs.push_back(rv(A_RESULT,      32'd0));
    vecs.push_back(rv(A_COUNT,       32'd0));
    vecs.push_back(wv(MMIO_BASE + 32'd4, 32'h1234_5678, 1'b0));
    vecs.push_back(rv(MMIO_BASE + 32'd4, 32'd0));
    vecs.push_back(rv(MMIO_BASE + 32'd15, 32'd0));
    vecs.push_back(wv(32'h0000_0FEF, 32'hA5A5_5A5A, 1'b1));
    vecs.push_back(rv(32'h0000_0FEF, 32'hA5A5_5A5A));
    vecs.push_back(wv(32'h0000_1000, 32'h5555_AAAA, 1'b1));
    vecs.push_back(rv(32'h0000_1000, 32'h5555_AAAA));
    vecs.push_back(wv(32'h0000_0011, 32'h0123_4567, 1'b1));
    vecs.push_back(rv(32'h0000_0011, 32'h0123_4567));
    vecs.push_back(rv(32'h0000_0010, 32'hDEAD_BEEF));

    reset               = 1'b0;
    sonar_echo          = 1'b0;
    bus_if.address_dmem = IDLE_ADDR;
    bus_if.data         = 32'd0;
    bus_if.wren         = 1'b0;

    repeat (3) @(negedge clock);
    check("reset sonar_trig", {31'd0, sonar_trig}, 32'd0);
    check("reset irq",        {31'd0, irq},        32'd0);
    check("reset q_dmem",     bus_if.q_dmem,       32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Decode / passthrough table.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        @(negedge clock);
        bus_if.address_dmem = vecs[i].addr;
        bus_if.data         = vecs[i].wdata;
        bus_if.wren         = 1'b1;
        #1;
        check($sformatf("vec%0d ram_wren", i), {31'd0, bus_if.ram_wren}, {31'd0, vecs[i].exp_wren});
        @(negedge clock);
        bus_if.wren         = 1'b0;
        bus_if.address_dmem = IDLE_ADDR;
        bus_if.data         = 32'd0;
      end else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d q_dmem", i), rd, vecs[i].exp_q);
      end
    end

    // Full measurement: 100-clock echo at 2 clocks per tick.
    bus_write(A_CMD, 32'd1);
    count_trig(n);
    check("t2 trig width", n, 32'd4);
    repeat (20) @(negedge clock);
    sonar_echo = 1'b1;
    repeat (100) @(negedge clock);
    sonar_echo = 1'b0;
    wait_irq(60, cyc);
    check("t2 irq", {31'd0, irq}, 32'd1);
    bus_read(A_STATUS, rd);
    check("t2 status done", rd, 32'd2);
    bus_read(A_RESULT, rd);
    check_range("t2 result", int'(rd), 49, 51);
    bus_read(A_COUNT, rd);
    check("t2 count", rd, 32'd1);
    check("t2 irq after result read", {31'd0, irq}, 32'd0);
    bus_read(A_STATUS, rd);
    check("t2 status after result read", rd, 32'd0);

    // No echo: timeout after 64 ticks in WAIT_ECHO.
    bus_write(A_CMD, 32'd1);
    count_trig(n);
    wait_irq(300, cyc);
    check("t3 irq", {31'd0, irq}, 32'd1);
    check_range("t3 timeout latency", cyc, 120, 140);
    bus_read(A_STATUS, rd);
    check("t3 status timeout", rd, 32'd6);
    bus_read(A_RESULT, rd);
    check("t3 result", rd, 32'd0);
    bus_read(A_STATUS, rd);
    check("t3 status after result read", rd, 32'd4);
    bus_write(A_CMD, 32'd2);
    bus_read(A_STATUS, rd);
    check("t3 status after clear", rd, 32'd0);
    bus_read(A_COUNT, rd);
    check("t3 count", rd, 32'd2);
    bus_write(A_COUNT, 32'h0000_1234);
    bus_read(A_COUNT, rd);
    check("count store clears", rd, 32'd0);

    // Stale echo: high before start, only the second pulse is measured.
    sonar_echo = 1'b1;
    repeat (5) @(negedge clock);
    bus_write(A_CMD, 32'd1);
    repeat (30) @(negedge clock);
    bus_read(A_STATUS, rd);
    check("t4 busy with stale echo", rd, 32'd1);
    sonar_echo = 1'b0;
    repeat (10) @(negedge clock);
    sonar_echo = 1'b1;
    repeat (40) @(negedge clock);
    sonar_echo = 1'b0;
    wait_irq(60, cyc);
    check("t4 irq", {31'd0, irq}, 32'd1);
    bus_read(A_STATUS, rd);
    check("t4 status", rd, 32'd2);
    bus_read(A_RESULT, rd);
    check_range("t4 result", int'(rd), 19, 21);
    bus_read(A_COUNT, rd);
    check("t4 count", rd, 32'd1);

    // Start while busy in MEASURE is ignored.
    bus_write(A_CMD, 32'd1);
    repeat (15) @(negedge clock);
    sonar_echo = 1'b1;
    repeat (10) @(negedge clock);
    bus_write(A_CMD, 32'd1);
    n = 0;
    for (int k = 0; k < 28; k++) begin
      if (sonar_trig) n++;
      @(negedge clock);
    end
    check("t5 no retrigger", n, 32'd0);
    sonar_echo = 1'b0;
    wait_irq(60, cyc);
    check("t5 irq", {31'd0, irq}, 32'd1);
    repeat (40) @(negedge clock);
    bus_read(A_STATUS, rd);
    check("t5 status idle", rd, 32'd2);
    bus_read(A_RESULT, rd);
    check_range("t5 result", int'(rd), 19, 21);
    bus_read(A_COUNT, rd);
    check("t5 count single", rd, 32'd2);

    // Reset during TRIG, released while echo is high.
    bus_write(A_CMD, 32'd1);
    @(negedge clock);
    check("t6 trig before reset", {31'd0, sonar_trig}, 32'd1);
    sonar_echo = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("t6 trig in reset", {31'd0, sonar_trig}, 32'd0);
    check("t6 q_dmem in reset", bus_if.q_dmem, 32'd0);
    check("t6 irq in reset", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    bus_read(A_STATUS, rd);
    check("t6 status after reset", rd, 32'd0);
    bus_read(A_COUNT, rd);
    check("t6 count after reset", rd, 32'd0);
    sonar_echo = 1'b0;
    repeat (5) @(negedge clock);
    sonar_echo = 1'b1;
    repeat (10) @(negedge clock);
    sonar_echo = 1'b0;
    repeat (10) @(negedge clock);
    bus_read(A_STATUS, rd);
    check("t6 no measurement without start", rd, 32'd0);
    bus_read(A_COUNT, rd);
    check("t6 count unchanged", rd, 32'd0);
    bus_write(A_STATUS, 32'hFFFF_FFFF);
    bus_read(A_STATUS, rd);
    check("t6 status store ignored", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
